fft_32: RTL and testbench



---
 rtl/fft32_pkg.sv | 47 ++++
 rtl/fft32_butterfly.sv | 65 ++++++
 rtl/fft_32.sv | 138 +++++++++++++
 tb/tb_fft_32.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft32_pkg.sv
// +----------------------------------------------------------------------------+
// | fft32_pkg : shared sizes, Q16.16 twiddle table and helpers for fft_32        |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

package fft32_pkg;

    localparam int N              = 32;
    localparam int LOG2N          = 5;
    localparam int ADC_WIDTH      = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_INTEGER    = 16;
    localparam int DEF_FRACTION   = 16;

    typedef struct packed {
        logic signed [DEF_DATA_WIDTH-1:0] re;
        logic signed [DEF_DATA_WIDTH-1:0] im;
    } cplx_t;

    // round(cos(2*pi*m/32) * 2^16) and round(-sin(2*pi*m/32) * 2^16)
    localparam int TW_RE [16] = '{ 65536,  64277,  60547,  54491,  46341,  36410,  25080,  12785,
                                       0, -12785, -25080, -36410, -46341, -54491, -60547, -64277};
    localparam int TW_IM [16] = '{     0, -12785, -25080, -36410, -46341, -54491, -60547, -64277,
                                  -65536, -64277, -60547, -54491, -46341, -36410, -25080, -12785};

    // Twiddle component rescaled from the Q.16 table to the requested fraction width
    function automatic logic signed [63:0] twiddle(input int m, input bit imag, input int frac);
        logic signed [63:0] q16;
        q16 = imag ? 64'(TW_IM[m]) : 64'(TW_RE[m]);
        if (frac >= 16)
            return q16 <<< (frac - 16);
        return q16 >>> (16 - frac);
    endfunction

    function automatic logic [LOG2N-1:0] bit_rev(input int idx);
        logic [LOG2N-1:0] v;
        logic [LOG2N-1:0] r;
        v = idx[LOG2N-1:0];
        for (int i = 0; i < LOG2N; i++)
            r[i] = v[LOG2N-1-i];
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft32_butterfly.sv
// +----------------------------------------------------------------------------+
// | fft32_butterfly : radix-2 DIT butterfly x = a + W*b, y = a - W*b             |
// | FFT32_ROUND_EN selects round-half-up on the twiddle product. Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module fft32_butterfly
    import fft32_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRACTION   = DEF_FRACTION,
    parameter int TW_IDX     = 0
) (
    input  logic signed [DATA_WIDTH-1:0] a_re,
    input  logic signed [DATA_WIDTH-1:0] a_im,
    input  logic signed [DATA_WIDTH-1:0] b_re,
    input  logic signed [DATA_WIDTH-1:0] b_im,
    output logic signed [DATA_WIDTH-1:0] x_re,
    output logic signed [DATA_WIDTH-1:0] x_im,
    output logic signed [DATA_WIDTH-1:0] y_re,
    output logic signed [DATA_WIDTH-1:0] y_im
);

    logic signed [DATA_WIDTH-1:0] w_wb_re;
    logic signed [DATA_WIDTH-1:0] w_wb_im;

    if (TW_IDX == 0) begin : g_bypass
        // W = 1 is exact, so the multiplier is skipped entirely
        assign w_wb_re = b_re;
        assign w_wb_im = b_im;
    end else begin : g_mult
        localparam logic signed [2*DATA_WIDTH-1:0] C_WR =
            (2*DATA_WIDTH)'(twiddle(TW_IDX, 1'b0, FRACTION));
        localparam logic signed [2*DATA_WIDTH-1:0] C_WI =
            (2*DATA_WIDTH)'(twiddle(TW_IDX, 1'b1, FRACTION));
`ifdef FFT32_ROUND_EN
        localparam logic signed [2*DATA_WIDTH-1:0] C_RND = (2*DATA_WIDTH)'(1) << (FRACTION - 1);
`else
        localparam logic signed [2*DATA_WIDTH-1:0] C_RND = '0;
`endif
        logic signed [2*DATA_WIDTH-1:0] w_bre;
        logic signed [2*DATA_WIDTH-1:0] w_bim;
        logic signed [2*DATA_WIDTH-1:0] w_pr;
        logic signed [2*DATA_WIDTH-1:0] w_pi;
        logic                           w_unused;

        assign w_bre = (2*DATA_WIDTH)'(b_re);
        assign w_bim = (2*DATA_WIDTH)'(b_im);
        assign w_pr  = w_bre * C_WR - w_bim * C_WI + C_RND;
        assign w_pi  = w_bre * C_WI + w_bim * C_WR + C_RND;
        // Dropping the low FRACTION bits of a two's-complement sum floors toward -inf
        assign w_wb_re = w_pr[FRACTION+DATA_WIDTH-1:FRACTION];
        assign w_wb_im = w_pi[FRACTION+DATA_WIDTH-1:FRACTION];
        assign w_unused = ^{w_pr[2*DATA_WIDTH-1:FRACTION+DATA_WIDTH], w_pr[FRACTION-1:0],
                            w_pi[2*DATA_WIDTH-1:FRACTION+DATA_WIDTH], w_pi[FRACTION-1:0]};
    end

    assign x_re = a_re + w_wb_re;
    assign x_im = a_im + w_wb_im;
    assign y_re = a_re - w_wb_re;
    assign y_im = a_im - w_wb_im;

endmodule

`default_nettype wire

// File: rtl/fft_32.sv
// +----------------------------------------------------------------------------+
// | fft_32 : 6-register pipelined 32-point radix-2 DIT FFT, natural-order out    |
// | Optional macro FFT32_ROUND_EN (rounding in butterflies). Rev 1.0             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fft_32
    import fft32_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int INTEGER    = DEF_INTEGER,
    parameter int FRACTION   = DEF_FRACTION
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PU_enable,
    input  logic [ADC_WIDTH-1:0]  ADC_in0_real,  ADC_in1_real,  ADC_in2_real,  ADC_in3_real,
                                  ADC_in4_real,  ADC_in5_real,  ADC_in6_real,  ADC_in7_real,
                                  ADC_in8_real,  ADC_in9_real,  ADC_in10_real, ADC_in11_real,
                                  ADC_in12_real, ADC_in13_real, ADC_in14_real, ADC_in15_real,
                                  ADC_in16_real, ADC_in17_real, ADC_in18_real, ADC_in19_real,
                                  ADC_in20_real, ADC_in21_real, ADC_in22_real, ADC_in23_real,
                                  ADC_in24_real, ADC_in25_real, ADC_in26_real, ADC_in27_real,
                                  ADC_in28_real, ADC_in29_real, ADC_in30_real, ADC_in31_real,
    output logic [DATA_WIDTH-1:0] FFT_RESULT_0_real,  FFT_RESULT_0_imag,  FFT_RESULT_1_real,  FFT_RESULT_1_imag,
                                  FFT_RESULT_2_real,  FFT_RESULT_2_imag,  FFT_RESULT_3_real,  FFT_RESULT_3_imag,
                                  FFT_RESULT_4_real,  FFT_RESULT_4_imag,  FFT_RESULT_5_real,  FFT_RESULT_5_imag,
                                  FFT_RESULT_6_real,  FFT_RESULT_6_imag,  FFT_RESULT_7_real,  FFT_RESULT_7_imag,
                                  FFT_RESULT_8_real,  FFT_RESULT_8_imag,  FFT_RESULT_9_real,  FFT_RESULT_9_imag,
                                  FFT_RESULT_10_real, FFT_RESULT_10_imag, FFT_RESULT_11_real, FFT_RESULT_11_imag,
                                  FFT_RESULT_12_real, FFT_RESULT_12_imag, FFT_RESULT_13_real, FFT_RESULT_13_imag,
                                  FFT_RESULT_14_real, FFT_RESULT_14_imag, FFT_RESULT_15_real, FFT_RESULT_15_imag,
                                  FFT_RESULT_16_real, FFT_RESULT_16_imag, FFT_RESULT_17_real, FFT_RESULT_17_imag,
                                  FFT_RESULT_18_real, FFT_RESULT_18_imag, FFT_RESULT_19_real, FFT_RESULT_19_imag,
                                  FFT_RESULT_20_real, FFT_RESULT_20_imag, FFT_RESULT_21_real, FFT_RESULT_21_imag,
                                  FFT_RESULT_22_real, FFT_RESULT_22_imag, FFT_RESULT_23_real, FFT_RESULT_23_imag,
                                  FFT_RESULT_24_real, FFT_RESULT_24_imag, FFT_RESULT_25_real, FFT_RESULT_25_imag,
                                  FFT_RESULT_26_real, FFT_RESULT_26_imag, FFT_RESULT_27_real, FFT_RESULT_27_imag,
                                  FFT_RESULT_28_real, FFT_RESULT_28_imag, FFT_RESULT_29_real, FFT_RESULT_29_imag,
                                  FFT_RESULT_30_real, FFT_RESULT_30_imag, FFT_RESULT_31_real, FFT_RESULT_31_imag
);

    logic        [ADC_WIDTH-1:0]  w_adc   [N];
    // w_nx_*[s] is the next value of pipeline register r_*[s]
    logic signed [DATA_WIDTH-1:0] w_nx_re [LOG2N+1][N];
    logic signed [DATA_WIDTH-1:0] w_nx_im [LOG2N+1][N];
    logic signed [DATA_WIDTH-1:0] r_re    [LOG2N+1][N];
    logic signed [DATA_WIDTH-1:0] r_im    [LOG2N+1][N];

    assign w_adc[0]  = ADC_in0_real;  assign w_adc[1]  = ADC_in1_real;  assign w_adc[2]  = ADC_in2_real;  assign w_adc[3]  = ADC_in3_real;
    assign w_adc[4]  = ADC_in4_real;  assign w_adc[5]  = ADC_in5_real;  assign w_adc[6]  = ADC_in6_real;  assign w_adc[7]  = ADC_in7_real;
    assign w_adc[8]  = ADC_in8_real;  assign w_adc[9]  = ADC_in9_real;  assign w_adc[10] = ADC_in10_real; assign w_adc[11] = ADC_in11_real;
    assign w_adc[12] = ADC_in12_real; assign w_adc[13] = ADC_in13_real; assign w_adc[14] = ADC_in14_real; assign w_adc[15] = ADC_in15_real;
    assign w_adc[16] = ADC_in16_real; assign w_adc[17] = ADC_in17_real; assign w_adc[18] = ADC_in18_real; assign w_adc[19] = ADC_in19_real;
    assign w_adc[20] = ADC_in20_real; assign w_adc[21] = ADC_in21_real; assign w_adc[22] = ADC_in22_real; assign w_adc[23] = ADC_in23_real;
    assign w_adc[24] = ADC_in24_real; assign w_adc[25] = ADC_in25_real; assign w_adc[26] = ADC_in26_real; assign w_adc[27] = ADC_in27_real;
    assign w_adc[28] = ADC_in28_real; assign w_adc[29] = ADC_in29_real; assign w_adc[30] = ADC_in30_real; assign w_adc[31] = ADC_in31_real;

    // Input register slot k holds sample bitrev(k), as an unsigned integer with zero fraction
    for (genvar k = 0; k < N; k++) begin : g_in
        localparam int C_SRC = int'(bit_rev(k));
        assign w_nx_re[0][k] = {{(INTEGER-ADC_WIDTH){1'b0}}, w_adc[C_SRC], {FRACTION{1'b0}}};
        assign w_nx_im[0][k] = '0;
    end

    // Stage s combines pairs 2^s apart; twiddle index is the in-group position scaled to W_32
    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam int C_HALF = 1 << s;
        for (genvar b = 0; b < N/2; b++) begin : g_bfly
            localparam int C_TOP = (b / C_HALF) * 2 * C_HALF + (b % C_HALF);
            localparam int C_TW  = (b % C_HALF) << (LOG2N - 1 - s);
            fft32_butterfly #(
                .DATA_WIDTH (DATA_WIDTH),
                .FRACTION   (FRACTION),
                .TW_IDX     (C_TW)
            ) u_bfly (
                .a_re (r_re[s][C_TOP]),
                .a_im (r_im[s][C_TOP]),
                .b_re (r_re[s][C_TOP+C_HALF]),
                .b_im (r_im[s][C_TOP+C_HALF]),
                .x_re (w_nx_re[s+1][C_TOP]),
                .x_im (w_nx_im[s+1][C_TOP]),
                .y_re (w_nx_re[s+1][C_TOP+C_HALF]),
                .y_im (w_nx_im[s+1][C_TOP+C_HALF])
            );
        end
    end

    for (genvar s = 0; s <= LOG2N; s++) begin : g_pipe
        for (genvar k = 0; k < N; k++) begin : g_word
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_re[s][k] <= '0;
                    r_im[s][k] <= '0;
                end else if (PU_enable) begin
                    r_re[s][k] <= w_nx_re[s][k];
                    r_im[s][k] <= w_nx_im[s][k];
                end
            end
        end
    end

    assign FFT_RESULT_0_real  = r_re[LOG2N][0];  assign FFT_RESULT_0_imag  = r_im[LOG2N][0];
    assign FFT_RESULT_1_real  = r_re[LOG2N][1];  assign FFT_RESULT_1_imag  = r_im[LOG2N][1];
    assign FFT_RESULT_2_real  = r_re[LOG2N][2];  assign FFT_RESULT_2_imag  = r_im[LOG2N][2];
    assign FFT_RESULT_3_real  = r_re[LOG2N][3];  assign FFT_RESULT_3_imag  = r_im[LOG2N][3];
    assign FFT_RESULT_4_real  = r_re[LOG2N][4];  assign FFT_RESULT_4_imag  = r_im[LOG2N][4];
    assign FFT_RESULT_5_real  = r_re[LOG2N][5];  assign FFT_RESULT_5_imag  = r_im[LOG2N][5];
    assign FFT_RESULT_6_real  = r_re[LOG2N][6];  assign FFT_RESULT_6_imag  = r_im[LOG2N][6];
    assign FFT_RESULT_7_real  = r_re[LOG2N][7];  assign FFT_RESULT_7_imag  = r_im[LOG2N][7];
    assign FFT_RESULT_8_real  = r_re[LOG2N][8];  assign FFT_RESULT_8_imag  = r_im[LOG2N][8];
    assign FFT_RESULT_9_real  = r_re[LOG2N][9];  assign FFT_RESULT_9_imag  = r_im[LOG2N][9];
    assign FFT_RESULT_10_real = r_re[LOG2N][10]; assign FFT_RESULT_10_imag = r_im[LOG2N][10];
    assign FFT_RESULT_11_real = r_re[LOG2N][11]; assign FFT_RESULT_11_imag = r_im[LOG2N][11];
    assign FFT_RESULT_12_real = r_re[LOG2N][12]; assign FFT_RESULT_12_imag = r_im[LOG2N][12];
    assign FFT_RESULT_13_real = r_re[LOG2N][13]; assign FFT_RESULT_13_imag = r_im[LOG2N][13];
    assign FFT_RESULT_14_real = r_re[LOG2N][14]; assign FFT_RESULT_14_imag = r_im[LOG2N][14];
    assign FFT_RESULT_15_real = r_re[LOG2N][15]; assign FFT_RESULT_15_imag = r_im[LOG2N][15];
    assign FFT_RESULT_16_real = r_re[LOG2N][16]; assign FFT_RESULT_16_imag = r_im[LOG2N][16];
    assign FFT_RESULT_17_real = r_re[LOG2N][17]; assign FFT_RESULT_17_imag = r_im[LOG2N][17];
    assign FFT_RESULT_18_real = r_re[LOG2N][18]; assign FFT_RESULT_18_imag = r_im[LOG2N][18];
    assign FFT_RESULT_19_real = r_re[LOG2N][19]; assign FFT_RESULT_19_imag = r_im[LOG2N][19];
    assign FFT_RESULT_20_real = r_re[LOG2N][20]; assign FFT_RESULT_20_imag = r_im[LOG2N][20];
    assign FFT_RESULT_21_real = r_re[LOG2N][21]; assign FFT_RESULT_21_imag = r_im[LOG2N][21];
    assign FFT_RESULT_22_real = r_re[LOG2N][22]; assign FFT_RESULT_22_imag = r_im[LOG2N][22];
    assign FFT_RESULT_23_real = r_re[LOG2N][23]; assign FFT_RESULT_23_imag = r_im[LOG2N][23];
    assign FFT_RESULT_24_real = r_re[LOG2N][24]; assign FFT_RESULT_24_imag = r_im[LOG2N][24];
    assign FFT_RESULT_25_real = r_re[LOG2N][25]; assign FFT_RESULT_25_imag = r_im[LOG2N][25];
    assign FFT_RESULT_26_real = r_re[LOG2N][26]; assign FFT_RESULT_26_imag = r_im[LOG2N][26];
    assign FFT_RESULT_27_real = r_re[LOG2N][27]; assign FFT_RESULT_27_imag = r_im[LOG2N][27];
    assign FFT_RESULT_28_real = r_re[LOG2N][28]; assign FFT_RESULT_28_imag = r_im[LOG2N][28];
    assign FFT_RESULT_29_real = r_re[LOG2N][29]; assign FFT_RESULT_29_imag = r_im[LOG2N][29];
    assign FFT_RESULT_30_real = r_re[LOG2N][30]; assign FFT_RESULT_30_imag = r_im[LOG2N][30];
    assign FFT_RESULT_31_real = r_re[LOG2N][31]; assign FFT_RESULT_31_imag = r_im[LOG2N][31];

endmodule

`default_nettype wire

// File: tb/tb_fft_32.sv
// +----------------------------------------------------------------------------+
// | tb_fft_32 : directed self-checking bench for fft_32                          |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fft_32;

    int checks = 0;
    int errors = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        PU_enable;
    logic [7:0]  adc [32];
    logic [31:0] re  [32];
    logic [31:0] im  [32];

    // Exact X[0] and X[16] of each frame kind: ramp, impulse, dc, pattern
    localparam logic [31:0] SIG_X0  [4] = '{32'h01F00000, 32'h00010000, 32'h00200000, 32'h00180000};
    localparam logic [31:0] SIG_X16 [4] = '{32'hFFF00000, 32'h00010000, 32'h00000000, 32'h00080000};

    logic [31:0] cur_x0, cur_x16;
    logic [31:0] pipe_x0 [6];
    logic [31:0] pipe_x16 [6];

    always #5 clk = ~clk;

    fft_32 dut (
        .clk(clk), .reset(reset), .PU_enable(PU_enable),
        .ADC_in0_real(adc[0]),   .ADC_in1_real(adc[1]),   .ADC_in2_real(adc[2]),   .ADC_in3_real(adc[3]),
        .ADC_in4_real(adc[4]),   .ADC_in5_real(adc[5]),   .ADC_in6_real(adc[6]),   .ADC_in7_real(adc[7]),
        .ADC_in8_real(adc[8]),   .ADC_in9_real(adc[9]),   .ADC_in10_real(adc[10]), .ADC_in11_real(adc[11]),
        .ADC_in12_real(adc[12]), .ADC_in13_real(adc[13]), .ADC_in14_real(adc[14]), .ADC_in15_real(adc[15]),
        .ADC_in16_real(adc[16]), .ADC_in17_real(adc[17]), .ADC_in18_real(adc[18]), .ADC_in19_real(adc[19]),
        .ADC_in20_real(adc[20]), .ADC_in21_real(adc[21]), .ADC_in22_real(adc[22]), .ADC_in23_real(adc[23]),
        .ADC_in24_real(adc[24]), .ADC_in25_real(adc[25]), .ADC_in26_real(adc[26]), .ADC_in27_real(adc[27]),
        .ADC_in28_real(adc[28]), .ADC_in29_real(adc[29]), .ADC_in30_real(adc[30]), .ADC_in31_real(adc[31]),
        .FFT_RESULT_0_real(re[0]),   .FFT_RESULT_0_imag(im[0]),   .FFT_RESULT_1_real(re[1]),   .FFT_RESULT_1_imag(im[1]),
        .FFT_RESULT_2_real(re[2]),   .FFT_RESULT_2_imag(im[2]),   .FFT_RESULT_3_real(re[3]),   .FFT_RESULT_3_imag(im[3]),
        .FFT_RESULT_4_real(re[4]),   .FFT_RESULT_4_imag(im[4]),   .FFT_RESULT_5_real(re[5]),   .FFT_RESULT_5_imag(im[5]),
        .FFT_RESULT_6_real(re[6]),   .FFT_RESULT_6_imag(im[6]),   .FFT_RESULT_7_real(re[7]),   .FFT_RESULT_7_imag(im[7]),
        .FFT_RESULT_8_real(re[8]),   .FFT_RESULT_8_imag(im[8]),   .FFT_RESULT_9_real(re[9]),   .FFT_RESULT_9_imag(im[9]),
        .FFT_RESULT_10_real(re[10]), .FFT_RESULT_10_imag(im[10]), .FFT_RESULT_11_real(re[11]), .FFT_RESULT_11_imag(im[11]),
        .FFT_RESULT_12_real(re[12]), .FFT_RESULT_12_imag(im[12]), .FFT_RESULT_13_real(re[13]), .FFT_RESULT_13_imag(im[13]),
        .FFT_RESULT_14_real(re[14]), .FFT_RESULT_14_imag(im[14]), .FFT_RESULT_15_real(re[15]), .FFT_RESULT_15_imag(im[15]),
        .FFT_RESULT_16_real(re[16]), .FFT_RESULT_16_imag(im[16]), .FFT_RESULT_17_real(re[17]), .FFT_RESULT_17_imag(im[17]),
        .FFT_RESULT_18_real(re[18]), .FFT_RESULT_18_imag(im[18]), .FFT_RESULT_19_real(re[19]), .FFT_RESULT_19_imag(im[19]),
        .FFT_RESULT_20_real(re[20]), .FFT_RESULT_20_imag(im[20]), .FFT_RESULT_21_real(re[21]), .FFT_RESULT_21_imag(im[21]),
        .FFT_RESULT_22_real(re[22]), .FFT_RESULT_22_imag(im[22]), .FFT_RESULT_23_real(re[23]), .FFT_RESULT_23_imag(im[23]),
        .FFT_RESULT_24_real(re[24]), .FFT_RESULT_24_imag(im[24]), .FFT_RESULT_25_real(re[25]), .FFT_RESULT_25_imag(im[25]),
        .FFT_RESULT_26_real(re[26]), .FFT_RESULT_26_imag(im[26]), .FFT_RESULT_27_real(re[27]), .FFT_RESULT_27_imag(im[27]),
        .FFT_RESULT_28_real(re[28]), .FFT_RESULT_28_imag(im[28]), .FFT_RESULT_29_real(re[29]), .FFT_RESULT_29_imag(im[29]),
        .FFT_RESULT_30_real(re[30]), .FFT_RESULT_30_imag(im[30]), .FFT_RESULT_31_real(re[31]), .FFT_RESULT_31_imag(im[31])
    );

    task automatic load_frame(input int kind);
        for (int n = 0; n < 32; n++) begin
            case (kind)
                0:       adc[n] = 8'(n);
                1:       adc[n] = (n == 0) ? 8'd1 : 8'd0;
                2:       adc[n] = 8'd1;
                default: adc[n] = (((n % 2) == 0 && n < 16) || n >= 16) ? 8'd1 : 8'd0;
            endcase
        end
        cur_x0  = SIG_X0[kind];
        cur_x16 = SIG_X16[kind];
    endtask

    // One clock; the frame-signature pipeline follows the DUT's register behaviour
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                pipe_x0[i]  = '0;
                pipe_x16[i] = '0;
            end
        end else if (PU_enable) begin
            for (int i = 5; i > 0; i--) begin
                pipe_x0[i]  = pipe_x0[i-1];
                pipe_x16[i] = pipe_x16[i-1];
            end
            pipe_x0[0]  = cur_x0;
            pipe_x16[0] = cur_x16;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        PU_enable = 1'b0;
        load_frame(0);
        for (int c = 0; c < 50; c++) tick();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (re[k] !== 32'h0 || im[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_zero bin %0d got %h/%h want 00000000/00000000", k, re[k], im[k]);
            end
        end
        reset = 1'b0;
        PU_enable = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (re[0] !== 32'h0 || im[1] !== 32'h0) begin
                errors++;
                $display("FAIL reset_fill clk %0d got X0re %h X1im %h want 0", c, re[0], im[1]);
            end
        end
    endtask

    task automatic test_ramp();
        int  kb [6] = '{1, 2, 4, 8, 24, 31};
        real ki [6] = '{162.4507262, 80.4374319, 38.6274170, 16.0, -16.0, -162.4507262};
        real v;
        tick();
        checks++;
        if (re[0] !== 32'h01F00000 || im[0] !== 32'h0) begin
            errors++;
            $display("FAIL ramp_x0 got %h/%h want 01f00000/00000000", re[0], im[0]);
        end
        checks++;
        if (re[16] !== 32'hFFF00000 || im[16] !== 32'h0) begin
            errors++;
            $display("FAIL ramp_x16 got %h/%h want fff00000/00000000", re[16], im[16]);
        end
        for (int k = 1; k < 32; k++) begin
            v = $itor($signed(re[k])) / 65536.0;
            checks++;
            if (v < -16.05 || v > -15.95) begin
                errors++;
                $display("FAIL ramp_re bin %0d got %f want -16.0", k, v);
            end
        end
        for (int i = 0; i < 6; i++) begin
            v = $itor($signed(im[kb[i]])) / 65536.0;
            checks++;
            if (v < ki[i] - 0.05 || v > ki[i] + 0.05) begin
                errors++;
                $display("FAIL ramp_im bin %0d got %f want %f", kb[i], v, ki[i]);
            end
        end
    endtask

    task automatic test_impulse();
        load_frame(1);
        for (int c = 0; c < 6; c++) tick();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (re[k] !== 32'h00010000 || im[k] !== 32'h0) begin
                errors++;
                $display("FAIL impulse bin %0d got %h/%h want 00010000/00000000", k, re[k], im[k]);
            end
        end
    endtask

    task automatic test_dc();
        load_frame(2);
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if (re[0] !== 32'h00200000 || im[0] !== 32'h0) begin
            errors++;
            $display("FAIL dc_x0 got %h/%h want 00200000/00000000", re[0], im[0]);
        end
        for (int k = 1; k < 32; k++) begin
            checks++;
            if ($signed(re[k]) > 8 || $signed(re[k]) < -8 || $signed(im[k]) > 8 || $signed(im[k]) < -8) begin
                errors++;
                $display("FAIL dc_bin %0d got %h/%h want within 8 LSB of 0", k, re[k], im[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int order [4] = '{3, 0, 1, 2};
        int c = 0;
        for (int f = 0; f < 4; f++) begin
            load_frame(order[f]);
            for (int r = 0; r < 4; r++) begin
                tick();
                c++;
                if (c == 6) begin
                    checks++;
                    if (re[0] !== 32'h00180000) begin
                        errors++;
                        $display("FAIL pattern_x0 got %h want 00180000", re[0]);
                    end
                end
                checks++;
                if (re[0] !== pipe_x0[5] || re[16] !== pipe_x16[5]) begin
                    errors++;
                    $display("FAIL b2b clk %0d got %h/%h want %h/%h", c, re[0], re[16], pipe_x0[5], pipe_x16[5]);
                end
            end
        end
    endtask

    task automatic test_stall();
        load_frame(0);
        tick(); tick();
        load_frame(1);
        tick();
        PU_enable = 1'b0;
        load_frame(2);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (re[0] !== pipe_x0[5] || re[16] !== pipe_x16[5]) begin
                errors++;
                $display("FAIL stall_hold clk %0d got %h/%h want %h/%h", c, re[0], re[16], pipe_x0[5], pipe_x16[5]);
            end
        end
        load_frame(3);
        PU_enable = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (re[0] !== pipe_x0[5] || re[16] !== pipe_x16[5]) begin
                errors++;
                $display("FAIL stall_resume clk %0d got %h/%h want %h/%h", c, re[0], re[16], pipe_x0[5], pipe_x16[5]);
            end
        end
    endtask

    task automatic test_reset_mid();
        load_frame(0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (re[k] !== 32'h0 || im[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_mid bin %0d got %h/%h want 00000000/00000000", k, re[k], im[k]);
            end
        end
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (re[0] !== 32'h0) begin
                errors++;
                $display("FAIL reset_mid_refill clk %0d got %h want 00000000", c, re[0]);
            end
        end
        tick();
        checks++;
        if (re[0] !== 32'h01F00000) begin
            errors++;
            $display("FAIL reset_mid_first got %h want 01f00000", re[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            pipe_x0[i]  = '0;
            pipe_x16[i] = '0;
        end
        test_reset();
        test_ramp();
        test_impulse();
        test_dc();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
